// File: rtl/lms_diq_deinterleave.sv
// rtl/lms_diq_deinterleave.sv - rebuilds aligned I/Q pairs from the interleaved LMS7002M DIQ stream
module lms_diq_deinterleave #(
    parameter int DATA_W     = 12,
    parameter int LOCK_PAIRS = 4,
    parameter int ERR_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] diq,
    input  logic              iqsel,
    input  logic              in_valid,
    output logic [DATA_W-1:0] i_out,
    output logic [DATA_W-1:0] q_out,
    output logic              out_valid,
    output logic              locked,
    output logic [ERR_W-1:0]  err_cnt
);

    typedef enum logic {SEEK_I, HAVE_I} state_t;

    localparam logic [8:0] LOCK_LIM = 9'(LOCK_PAIRS);

    state_t            state;
    logic [DATA_W-1:0] i_hold;
    logic [7:0]        good_run;
    logic [8:0]        good_next;
    logic              release_pair;

    assign good_next    = {1'b0, good_run} + 9'd1;
    assign release_pair = (good_next >= LOCK_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEEK_I;
            i_hold    <= '0;
            i_out     <= '0;
            q_out     <= '0;
            out_valid <= 1'b0;
            locked    <= 1'b0;
            good_run  <= '0;
            err_cnt   <= '0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                case (state)
                    SEEK_I: begin
                        if (iqsel) begin
                            i_hold <= diq;
                            state  <= HAVE_I;
                        end else begin
                            // Stray Q: drop the word and restart lock qualification
                            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                            good_run <= '0;
                            locked   <= 1'b0;
                        end
                    end
                    HAVE_I: begin
                        if (!iqsel) begin
                            state <= SEEK_I;
                            if (good_next <= LOCK_LIM) good_run <= good_next[7:0];
                            if (release_pair) begin
                                i_out     <= i_hold;
                                q_out     <= diq;
                                out_valid <= 1'b1;
                                locked    <= 1'b1;
                            end
                        end else begin
                            // Repeated I: the newest I is kept as the pair's I
                            i_hold <= diq;
                            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                            good_run <= '0;
                            locked   <= 1'b0;
                        end
                    end
                    default: state <= SEEK_I;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lms_diq_deinterleave.sv
// tb/tb_lms_diq_deinterleave.sv - directed self-checking bench for lms_diq_deinterleave
module tb_lms_diq_deinterleave;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] diq = '0;
    logic        iqsel = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] i_out;
    logic [11:0] q_out;
    logic        out_valid;
    logic        locked;
    logic [15:0] err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lms_diq_deinterleave #(.DATA_W(12), .LOCK_PAIRS(4), .ERR_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .diq(diq), .iqsel(iqsel), .in_valid(in_valid),
        .i_out(i_out), .q_out(q_out), .out_valid(out_valid), .locked(locked), .err_cnt(err_cnt)
    );

    // Drive at a falling edge; on return the next falling edge has passed the rising edge
    task automatic step(input logic v, input logic s, input logic [11:0] d);
        in_valid = v;
        iqsel    = s;
        diq      = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0h want 0", out_valid); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %0h want 0", locked); end
        checks++; if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt got %0h want 0", err_cnt); end
        checks++; if (i_out !== 12'h0 || q_out !== 12'h0) begin errors++; $display("FAIL reset_iq got %0h/%0h want 0/0", i_out, q_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_lock();
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 1'b1, 12'h100);
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lock_i_strobe pair %0d got %0h want 0", p, out_valid); end
            step(1'b1, 1'b0, 12'h200);
            if (p < 3) begin
                checks++; if (out_valid !== 1'b0 || locked !== 1'b0) begin errors++; $display("FAIL lock_early pair %0d valid=%0h locked=%0h want 0/0", p, out_valid, locked); end
            end
        end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lock_release got %0h want 1", out_valid); end
        checks++; if (i_out !== 12'h100 || q_out !== 12'h200) begin errors++; $display("FAIL lock_data got %0h/%0h want 100/200", i_out, q_out); end
        checks++; if (locked !== 1'b1 || err_cnt !== 16'h0) begin errors++; $display("FAIL lock_state locked=%0h err=%0h want 1/0", locked, err_cnt); end
        step(1'b0, 1'b0, 12'h000);
        checks++; if (out_valid !== 1'b0 || i_out !== 12'h100) begin errors++; $display("FAIL lock_strobe_drop valid=%0h i=%0h want 0/100", out_valid, i_out); end
    endtask

    task automatic test_stray_q();
        int strobes;
        step(1'b1, 1'b1, 12'h111);
        step(1'b1, 1'b0, 12'h222);
        checks++; if (out_valid !== 1'b1 || q_out !== 12'h222) begin errors++; $display("FAIL stray_pre valid=%0h q=%0h want 1/222", out_valid, q_out); end
        step(1'b1, 1'b0, 12'h333);
        checks++; if (err_cnt !== 16'd1 || locked !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL stray_err err=%0h locked=%0h valid=%0h want 1/0/0", err_cnt, locked, out_valid); end
        strobes = 0;
        for (int p = 0; p < 3; p++) begin
            step(1'b1, 1'b1, 12'h010 + 12'(p));
            if (out_valid) strobes++;
            step(1'b1, 1'b0, 12'h020 + 12'(p));
            if (out_valid) strobes++;
        end
        checks++; if (strobes !== 0 || i_out !== 12'h111 || q_out !== 12'h222) begin errors++; $display("FAIL stray_unlocked strobes=%0d i=%0h q=%0h want 0/111/222", strobes, i_out, q_out); end
        step(1'b1, 1'b1, 12'h013);
        step(1'b1, 1'b0, 12'h023);
        checks++; if (out_valid !== 1'b1 || locked !== 1'b1 || i_out !== 12'h013 || q_out !== 12'h023) begin errors++; $display("FAIL stray_relock valid=%0h locked=%0h i=%0h q=%0h want 1/1/13/23", out_valid, locked, i_out, q_out); end
    endtask

    task automatic test_repeat_i();
        step(1'b1, 1'b1, 12'h0AA);
        step(1'b1, 1'b1, 12'h0BB);
        checks++; if (err_cnt !== 16'd2 || locked !== 1'b0) begin errors++; $display("FAIL repi_err err=%0h locked=%0h want 2/0", err_cnt, locked); end
        step(1'b1, 1'b0, 12'hFFF);
        checks++; if (out_valid !== 1'b0 || i_out !== 12'h013) begin errors++; $display("FAIL repi_unreleased valid=%0h i=%0h want 0/13", out_valid, i_out); end
        for (int p = 0; p < 3; p++) begin
            step(1'b1, 1'b1, 12'h0BB);
            step(1'b1, 1'b0, 12'h0C0 + 12'(p));
        end
        checks++; if (out_valid !== 1'b1 || i_out !== 12'h0BB || q_out !== 12'h0C2) begin errors++; $display("FAIL repi_release valid=%0h i=%0h q=%0h want 1/bb/c2", out_valid, i_out, q_out); end
    endtask

    task automatic test_gap();
        int bad;
        step(1'b1, 1'b1, 12'h123);
        bad = 0;
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, 12'hEEE);
            if (out_valid !== 1'b0 || i_out !== 12'h0BB || q_out !== 12'h0C2) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL gap_hold bad_cycles=%0d want 0", bad); end
        step(1'b1, 1'b0, 12'h456);
        checks++; if (out_valid !== 1'b1 || i_out !== 12'h123 || q_out !== 12'h456) begin errors++; $display("FAIL gap_release valid=%0h i=%0h q=%0h want 1/123/456", out_valid, i_out, q_out); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] pat;
        for (int k = 0; k < 6; k++) begin
            step(1'b1, (k % 2) == 0, 12'h800 + 12'(k));
            pat[k] = out_valid;
        end
        checks++; if (pat !== 6'b101010) begin errors++; $display("FAIL b2b_pattern got %b want 101010", pat); end
        checks++; if (i_out !== 12'h804 || q_out !== 12'h805) begin errors++; $display("FAIL b2b_data got %0h/%0h want 804/805", i_out, q_out); end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b1, 12'h777);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (i_out !== 12'h0 || q_out !== 12'h0 || out_valid !== 1'b0 || locked !== 1'b0 || err_cnt !== 16'h0) begin
            errors++; $display("FAIL async_reset i=%0h q=%0h valid=%0h locked=%0h err=%0h want all 0", i_out, q_out, out_valid, locked, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 12'h050);
        checks++; if (err_cnt !== 16'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL async_lone_q err=%0h valid=%0h want 1/0", err_cnt, out_valid); end
    endtask

    task automatic test_err_sat();
        for (int k = 0; k < 65541; k++) step(1'b1, 1'b0, 12'h001);
        checks++; if (err_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_value got %0h want ffff", err_cnt); end
        for (int p = 0; p < 4; p++) begin
            step(1'b1, 1'b1, 12'h300);
            step(1'b1, 1'b0, 12'h400);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL sat_relock got %0h want 1", locked); end
        step(1'b1, 1'b0, 12'h001);
        checks++; if (err_cnt !== 16'hFFFF || locked !== 1'b0) begin errors++; $display("FAIL sat_hold err=%0h locked=%0h want ffff/0", err_cnt, locked); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_stray_q();
        test_repeat_i();
        test_gap();
        test_back_to_back();
        test_async_reset();
        test_err_sat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
